// File: rtl/led_pkg.sv
// led_pkg: shared types and default constants for the LED runner.
// Provides the runner state enum and default width/debounce settings.
package led_pkg;

  localparam int LED_W_DEF    = 8;
  localparam int DEBOUNCE_DEF = 1_000_000;

  typedef enum logic [1:0] {
    RUN_UP   = 2'd0,
    RUN_DN   = 2'd1,
    PAUSE_UP = 2'd2,
    PAUSE_DN = 2'd3
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop sync plus stable-time filter for a raw key.
// Ports: i_clk, i_rst_n, i_key_n (raw, active-low) -> o_press (1-cycle).
module key_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Count consecutive cycles where the synced key disagrees with
  // the stable value; any agreement restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      stable  <= 1'b1;
      cnt     <= '0;
      o_press <= 1'b0;
    end else begin
      sync1   <= i_key_n;
      sync2   <= sync1;
      o_press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt     <= '0;
        stable  <= sync2;
        o_press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_runner.sv
// led_runner: one-hot LED chaser, circular or ping-pong, key pause.
// Ports: i_next_led step, i_key_n, i_dir, i_bounce -> o_led/o_wrap/o_paused.
module led_runner
  import led_pkg::*;
#(
  parameter int LED_W           = LED_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_next_led,
  input  logic             i_key_n,
  input  logic             i_dir,
  input  logic             i_bounce,
  output logic [LED_W-1:0] o_led,
  output logic             o_wrap,
  output logic             o_paused
);

  localparam logic [LED_W-1:0] LSB  = LED_W'(1);
  localparam logic [LED_W-1:0] LSB2 = LSB << 1;
  localparam logic [LED_W-1:0] MSB  = LSB << (LED_W - 1);
  localparam logic [LED_W-1:0] MSB2 = LSB << (LED_W - 2);

  state_t state;
  logic   press;
  logic   led_ok;
  logic   at_top;
  logic   at_bot;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_key_n(i_key_n),
    .o_press(press)
  );

  // Exactly one bit set; anything else forces recovery.
  assign led_ok = (o_led != '0) &&
                  ((o_led & (o_led - 1'b1)) == '0);
  assign at_top = o_led[LED_W-1];
  assign at_bot = o_led[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= RUN_UP;
      o_led    <= LSB;
      o_wrap   <= 1'b0;
      o_paused <= 1'b0;
    end else begin
      o_wrap <= 1'b0;
      if (!led_ok) begin
        state    <= RUN_UP;
        o_led    <= LSB;
        o_paused <= 1'b0;
      end else begin
        case (state)
          RUN_UP, RUN_DN: begin
            // A press wins over a step in the same cycle.
            if (press) begin
              state    <= (state == RUN_UP) ? PAUSE_UP : PAUSE_DN;
              o_paused <= 1'b1;
            end else if (i_next_led) begin
              if (!i_bounce) begin
                if (i_dir) begin
                  state  <= RUN_UP;
                  o_led  <= at_top ? LSB : (o_led << 1);
                  o_wrap <= at_top;
                end else begin
                  state  <= RUN_DN;
                  o_led  <= at_bot ? MSB : (o_led >> 1);
                  o_wrap <= at_bot;
                end
              end else if (state == RUN_UP) begin
                if (at_top) begin
                  state  <= RUN_DN;
                  o_led  <= MSB2;
                  o_wrap <= 1'b1;
                end else begin
                  o_led <= o_led << 1;
                end
              end else begin
                if (at_bot) begin
                  state  <= RUN_UP;
                  o_led  <= LSB2;
                  o_wrap <= 1'b1;
                end else begin
                  o_led <= o_led >> 1;
                end
              end
            end
          end
          PAUSE_UP: begin
            if (press) begin
              state    <= RUN_UP;
              o_paused <= 1'b0;
            end
          end
          PAUSE_DN: begin
            if (press) begin
              state    <= RUN_DN;
              o_paused <= 1'b0;
            end
          end
          default: begin
            state    <= RUN_UP;
            o_led    <= LSB;
            o_paused <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_runner.sv
// tb_led_runner: directed vector table plus key/reset sequences.
// Drives and samples on the falling clock edge.
module tb_led_runner;

  localparam int W  = 8;
  localparam int DB = 4;

  logic         i_clk      = 1'b0;
  logic         i_rst_n    = 1'b0;
  logic         i_next_led = 1'b0;
  logic         i_key_n    = 1'b1;
  logic         i_dir      = 1'b0;
  logic         i_bounce   = 1'b0;
  logic [W-1:0] o_led;
  logic         o_wrap;
  logic         o_paused;

  int   checks        = 0;
  int   failures      = 0;
  int   pause_changes = 0;
  logic prev_paused   = 1'b0;

  typedef struct {
    logic         nxt;
    logic         dir;
    logic         bnc;
    logic [W-1:0] led;
    logic         wrap;
  } vec_t;

  vec_t v[$];

  always #5 i_clk = ~i_clk;

  led_runner #(
    .LED_W          (W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_next_led(i_next_led),
    .i_key_n   (i_key_n),
    .i_dir     (i_dir),
    .i_bounce  (i_bounce),
    .o_led     (o_led),
    .o_wrap    (o_wrap),
    .o_paused  (o_paused)
  );

  always @(negedge i_clk) begin
    if (o_paused !== prev_paused) pause_changes++;
    prev_paused = o_paused;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      i_next_led = v[i].nxt;
      i_dir      = v[i].dir;
      i_bounce   = v[i].bnc;
      @(negedge i_clk);
      check($sformatf("vec%0d_led", i), 32'(o_led), 32'(v[i].led));
      check($sformatf("vec%0d_wrap", i), 32'(o_wrap), 32'(v[i].wrap));
    end
    i_next_led = 1'b0;
  endtask

  task automatic key_hold(input logic val, input int n);
    i_key_n = val;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic press_key();
    key_hold(1'b0, 10);
    key_hold(1'b1, 10);
  endtask

  task automatic step_expect(input string name, input logic [W-1:0] exp);
    i_next_led = 1'b1;
    @(negedge i_clk);
    i_next_led = 1'b0;
    check({name, "_led"}, 32'(o_led), 32'(exp));
  endtask

  initial begin
    // circular walk up
    v.push_back('{1'b0, 1'b1, 1'b0, 8'h01, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 8'h02, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 8'h04, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 8'h08, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 8'h10, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 8'h20, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 8'h40, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 8'h80, 1'b0});
    v.push_back('{1'b1, 1'b1, 1'b0, 8'h01, 1'b1});
    // ping-pong, i_dir ignored
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h02, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h04, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h08, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h10, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h20, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h40, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h80, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h40, 1'b1});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h20, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h10, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h08, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h04, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h02, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h01, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b1, 8'h02, 1'b1});
    v.push_back('{1'b0, 1'b0, 1'b1, 8'h02, 1'b0});
    // circular down, step held high
    v.push_back('{1'b1, 1'b0, 1'b0, 8'h80, 1'b1});
    v.push_back('{1'b1, 1'b0, 1'b0, 8'h40, 1'b0});
    v.push_back('{1'b1, 1'b0, 1'b0, 8'h20, 1'b0});
    v.push_back('{1'b0, 1'b0, 1'b0, 8'h20, 1'b0});

    // reset state
    repeat (2) @(negedge i_clk);
    check("rst_led", 32'(o_led), 32'h01);
    check("rst_wrap", 32'(o_wrap), 32'h0);
    check("rst_paused", 32'(o_paused), 32'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_vecs(0, 24);

    // bouncy press: exactly one pause toggle
    pause_changes = 0;
    key_hold(1'b0, 2);
    key_hold(1'b1, 1);
    key_hold(1'b0, 2);
    key_hold(1'b1, 1);
    key_hold(1'b0, 10);
    key_hold(1'b1, 10);
    check("bounce_paused", 32'(o_paused), 32'h1);
    check("bounce_presses", 32'(pause_changes), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step_expect($sformatf("paused_step%0d", i), 8'h02);
      check($sformatf("paused_wrap%0d", i), 32'(o_wrap), 32'h0);
    end

    // resume, still running upward
    press_key();
    check("resume_paused", 32'(o_paused), 32'h0);
    step_expect("resume_step", 8'h04);

    // press and step in the same cycle
    i_key_n = 1'b0;
    repeat (6) @(negedge i_clk);
    i_next_led = 1'b1;
    @(negedge i_clk);
    i_next_led = 1'b0;
    check("coinc_paused", 32'(o_paused), 32'h1);
    check("coinc_led", 32'(o_led), 32'h04);
    check("coinc_wrap", 32'(o_wrap), 32'h0);
    key_hold(1'b0, 3);
    key_hold(1'b1, 10);
    press_key();
    check("coinc_resume", 32'(o_paused), 32'h0);
    step_expect("dir_kept1", 8'h08);
    step_expect("dir_kept2", 8'h10);
    step_expect("dir_kept3", 8'h20);

    // async reset while paused
    press_key();
    check("pre_rst_paused", 32'(o_paused), 32'h1);
    check("pre_rst_led", 32'(o_led), 32'h20);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(o_led), 32'h01);
    check("async_rst_paused", 32'(o_paused), 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_vecs(25, 28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
